flow_source: RTL and testbench
==============================

FLOW_SOURCE -- requirements
Module: flow_source

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each data word written to the FIFO.
REQ-002 Parameter COUNT_WIDTH, default 8, width of the burst-length and sent-word counters.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 iniciar  input  1  start request; sampled only in state IDLE.
REQ-006 cantidad  input  COUNT_WIDTH  number of words in the burst; latched when iniciar is accepted.
REQ-007 semilla  input  DATA_WIDTH  first data word of the burst; latched when iniciar is accepted.
REQ-008 pausa  input  1  pause command from the flow-control FSM.
REQ-009 continuar  input  1  resume command from the flow-control FSM.
REQ-010 idle  input  1  FIFO-empty indication from the flow-control FSM; also acts as a resume.
REQ-011 error_full  input  1  FIFO-overflow indication from the flow-control FSM.
REQ-012 fifo_full  input  1  raw FIFO full flag; local write guard.
REQ-013 push  output  1  FIFO write strobe, registered.
REQ-014 data_out  output  DATA_WIDTH  FIFO write data, registered; valid when push=1.
REQ-015 enviados  output  COUNT_WIDTH  count of words pushed in the current burst, registered.
REQ-016 busy  output  1  high in states SEND and HOLD.
REQ-017 done  output  1  one-cycle pulse on burst completion.
REQ-018 error_out  output  1  sticky error indication, high in state ERROR.

Function
REQ-019 The block SHALL implement the states IDLE, SEND, HOLD, ERROR and DONE, encoded one-hot.
REQ-020 IDLE SHALL behave as follows: iniciar=1 with cantidad!=0 latches cantidad and semilla, clears enviados, and moves to SEND; iniciar=1 with cantidad=0 moves to DONE; otherwise the state holds.
REQ-021 In SEND, each edge with error_full=0, pausa=0 and fifo_full=0 SHALL register push=1 and data_out=semilla+enviados (modulo 2^DATA_WIDTH), and SHALL increment enviados.
REQ-022 In SEND, an edge with fifo_full=1 and no higher-priority event SHALL register push=0 and stay in SEND without advancing enviados.
REQ-023 In SEND, pausa=1 SHALL register push=0 and move to HOLD.
REQ-024 In SEND, the push that makes enviados equal the latched cantidad SHALL move the block to DONE on that edge.
REQ-025 In HOLD, push SHALL be 0; continuar=1 or idle=1 SHALL return the block to SEND; otherwise it stays in HOLD.
REQ-026 In SEND and HOLD, error_full=1 SHALL move the block to ERROR with push=0, overriding every other input.
REQ-027 Input priority in SEND SHALL be error_full > pausa > fifo_full > normal push.
REQ-028 DONE SHALL assert done=1 for exactly one cycle, keep enviados at its final value, and return to IDLE.
REQ-029 ERROR SHALL hold error_out=1 and push=0 and SHALL be left only through reset.
REQ-030 iniciar SHALL be ignored outside IDLE.
REQ-031 Latency SHALL be as follows: iniciar accepted at edge N gives the first push=1 visible after edge N+1, provided no pause or full condition intervenes.
REQ-032 The data word SHALL never be skipped or repeated across pause, fifo_full stalls or resume; data_out after resume continues at semilla+enviados.

Reset
REQ-033 When reset=0 at a rising edge, the block SHALL enter IDLE and set push=0, data_out=0, enviados=0, busy=0, done=0 and error_out=0.
REQ-034 Reset SHALL take effect from any state, including mid-burst and ERROR, and no push SHALL occur in the cycle following a reset edge.

Verification
REQ-035 Burst: cantidad=4, semilla=0x10, no stalls -> four consecutive pushes with data 0x10..0x13, then done pulses once, enviados=4, and the block returns to IDLE.
REQ-036 Pause: cantidad=6, pausa=1 after 2 pushes, continuar=1 three cycles later -> no push while in HOLD, data resumes at semilla+2, and exactly 6 words are pushed in total.
REQ-037 Full stall: fifo_full=1 for 3 cycles mid-burst -> push=0 during those cycles, no data word is skipped, and enviados is frozen.
REQ-038 Error: error_full=1 together with pausa=1 during SEND -> ERROR, error_out=1 and push=0 persist, and a later iniciar is ignored.
REQ-039 Reset mid-burst: reset=0 after 3 of 8 pushes -> all outputs are 0 and the block is in IDLE; a new iniciar restarts with enviados=0.
REQ-040 Zero length: iniciar with cantidad=0 -> no push, done pulses for one cycle, and the block returns to IDLE.

Source files
------------

// File: rtl/flow_source.sv
// rtl/flow_source.sv - burst word source writing an incrementing data sequence into a FIFO under flow control
module flow_source #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [COUNT_WIDTH-1:0] cantidad,
  input  logic [DATA_WIDTH-1:0]  semilla,
  input  logic                   pausa,
  input  logic                   continuar,
  input  logic                   idle,
  input  logic                   error_full,
  input  logic                   fifo_full,
  output logic                   push,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic [COUNT_WIDTH-1:0] enviados,
  output logic                   busy,
  output logic                   done,
  output logic                   error_out
);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_SEND  = 5'b00010,
    S_HOLD  = 5'b00100,
    S_ERROR = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  state_t                 state_q, state_d;
  logic                   push_q, push_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [DATA_WIDTH-1:0]  seed_q, seed_d;
  logic [COUNT_WIDTH-1:0] sent_q, sent_d;
  logic [COUNT_WIDTH-1:0] len_q, len_d;
  logic [COUNT_WIDTH-1:0] sent_inc;

  assign sent_inc = sent_q + COUNT_WIDTH'(1);

  // State register and datapath flops; reset returns to IDLE with every output cleared
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      push_q  <= 1'b0;
      data_q  <= '0;
      seed_q  <= '0;
      sent_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      push_q  <= push_d;
      data_q  <= data_d;
      seed_q  <= seed_d;
      sent_q  <= sent_d;
      len_q   <= len_d;
    end
  end

  // Next state and push decision; in SEND error_full beats pausa beats fifo_full beats a normal push
  always_comb begin
    state_d = state_q;
    push_d  = 1'b0;
    data_d  = data_q;
    seed_d  = seed_q;
    sent_d  = sent_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (iniciar) begin
          sent_d = '0;
          if (cantidad == '0) begin
            state_d = S_DONE;
          end else begin
            len_d   = cantidad;
            seed_d  = semilla;
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (error_full) begin
          state_d = S_ERROR;
        end else if (pausa) begin
          state_d = S_HOLD;
        end else if (!fifo_full) begin
          // The word is always seed plus words already sent, so stalls and pauses never skip or repeat
          push_d = 1'b1;
          data_d = seed_q + DATA_WIDTH'(sent_q);
          sent_d = sent_inc;
          if (sent_inc == len_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_HOLD: begin
        if (error_full) begin
          state_d = S_ERROR;
        end else if (continuar || idle) begin
          state_d = S_SEND;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign push      = push_q;
  assign data_out  = data_q;
  assign enviados  = sent_q;
  assign busy      = (state_q == S_SEND) || (state_q == S_HOLD);
  assign done      = (state_q == S_DONE);
  assign error_out = (state_q == S_ERROR);

endmodule

// File: tb/tb_flow_source.sv
// tb/tb_flow_source.sv - randomized and directed bench for flow_source against a behavioural model
module tb_flow_source;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [7:0] cantidad = '0;
  logic [7:0] semilla = '0;
  logic       pausa = 1'b0;
  logic       continuar = 1'b0;
  logic       idle_in = 1'b0;
  logic       error_full = 1'b0;
  logic       fifo_full = 1'b0;
  logic       push;
  logic [7:0] data_out;
  logic [7:0] enviados;
  logic       busy;
  logic       done;
  logic       error_out;

  int total = 0;
  int bad   = 0;
  int n_push = 0;
  int n_done = 0;

  flow_source #(.DATA_WIDTH(8), .COUNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .cantidad(cantidad), .semilla(semilla),
    .pausa(pausa), .continuar(continuar), .idle(idle_in), .error_full(error_full),
    .fifo_full(fifo_full), .push(push), .data_out(data_out), .enviados(enviados),
    .busy(busy), .done(done), .error_out(error_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: which phase the burst is in, how many words are sent, and what was written last
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3, M_FAILED = 4;
  int         m_phase = M_IDLE;
  int         m_sent  = 0;
  int         m_len   = 0;
  int         m_seed  = 0;
  logic       e_push  = 1'b0;
  logic [7:0] e_data  = '0;

  function automatic void model_edge();
    e_push = 1'b0;
    if (!reset) begin
      m_phase = M_IDLE;
      m_sent  = 0;
      e_data  = '0;
      m_len   = 0;
      m_seed  = 0;
    end else if (m_phase == M_IDLE) begin
      if (iniciar) begin
        m_sent = 0;
        if (cantidad == 0) begin
          m_phase = M_DONE;
        end else begin
          m_len   = int'(cantidad);
          m_seed  = int'(semilla);
          m_phase = M_RUN;
        end
      end
    end else if (m_phase == M_RUN) begin
      if (error_full) m_phase = M_FAILED;
      else if (pausa) m_phase = M_PAUSED;
      else if (!fifo_full) begin
        e_push = 1'b1;
        e_data = 8'((m_seed + m_sent) % 256);
        m_sent = m_sent + 1;
        if (m_sent == m_len) m_phase = M_DONE;
      end
    end else if (m_phase == M_PAUSED) begin
      if (error_full) m_phase = M_FAILED;
      else if (continuar || idle_in) m_phase = M_RUN;
    end else if (m_phase == M_DONE) begin
      m_phase = M_IDLE;
    end
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic st, input logic [7:0] len, input logic [7:0] sd,
                      input logic pz, input logic ct, input logic id, input logic ef, input logic ff);
    reset = r; iniciar = st; cantidad = len; semilla = sd;
    pausa = pz; continuar = ct; idle_in = id; error_full = ef; fifo_full = ff;
    @(posedge clk);
    model_edge();
    #1;
    check_val("push", push, e_push);
    check_val("data_out", data_out, e_data);
    check_val("enviados", enviados, 32'(m_sent));
    check_val("busy", busy, (m_phase == M_RUN) || (m_phase == M_PAUSED));
    check_val("done", done, m_phase == M_DONE);
    check_val("error_out", error_out, m_phase == M_FAILED);
    if (push) n_push++;
    if (done) n_done++;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 8'h33, 0, 0, 0, 0, 0);
    check_val("reset_push", push, 0);
    check_val("reset_data", data_out, 0);

    // Plain burst of four from 0x10
    n_push = 0; n_done = 0;
    step(1, 1, 4, 8'h10, 0, 0, 0, 0, 0);
    check_val("latency_no_push_yet", push, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("first_word", data_out, 8'h10);
    quiet(6);
    check_val("burst_pushes", n_push, 4);
    check_val("burst_done_once", n_done, 1);
    check_val("burst_final_count", enviados, 4);

    // Pause after two words, resume three cycles later
    n_push = 0; n_done = 0;
    step(1, 1, 6, 8'h40, 0, 0, 0, 0, 0);
    quiet(2);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    quiet(3);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("resume_word", data_out, 8'h42);
    quiet(8);
    check_val("pause_pushes", n_push, 6);

    // FIFO full for three cycles mid-burst, with data wrapping past 0xFF
    n_push = 0;
    step(1, 1, 5, 8'hFE, 0, 0, 0, 0, 0);
    quiet(2);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    check_val("stall_frozen", enviados, 2);
    quiet(6);
    check_val("stall_pushes", n_push, 5);

    // Overflow together with pause goes to ERROR and stays there
    step(1, 1, 8, 8'h01, 0, 0, 0, 0, 0);
    quiet(1);
    step(1, 0, 0, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 3, 8'h00, 0, 1, 1, 0, 0);
    check_val("error_sticky", error_out, 1);

    // Reset after three of eight words, then restart
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8, 8'h80, 0, 0, 0, 0, 0);
    quiet(3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("midreset_count", enviados, 0);
    check_val("midreset_busy", busy, 0);
    step(1, 1, 3, 8'h20, 0, 0, 0, 0, 0);
    quiet(5);

    // Zero-length burst
    n_push = 0; n_done = 0;
    step(1, 1, 0, 8'h55, 0, 0, 0, 0, 0);
    quiet(3);
    check_val("zero_pushes", n_push, 0);
    check_val("zero_done_once", n_done, 1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(199) != 0,
           $urandom_range(2) == 0,
           ($urandom_range(9) == 0) ? 8'($urandom) : 8'($urandom_range(9)),
           8'($urandom),
           $urandom_range(5) == 0,
           $urandom_range(3) == 0,
           $urandom_range(7) == 0,
           $urandom_range(149) == 0,
           $urandom_range(4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
